// File: rtl/bp_pkg.sv
// Shared defaults and helpers for the n-bit saturating-counter branch predictor.
package bp_pkg;

  localparam int unsigned DEF_IDX_W  = 3;
  localparam int unsigned DEF_CNT_W  = 2;
  localparam int unsigned DEF_STAT_W = 16;

  // Weakly not-taken: the largest value whose MSB is still 0.
  function automatic int unsigned cnt_init(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down saturating counter used as one prediction table entry.
module sat_counter #(
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned INIT_VAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] One    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MaxVal = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MinVal = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] Init   = INIT_VAL[CNT_W-1:0];

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      if (up) begin
        if (count_q != MaxVal) count_d = count_q + One;
      end else begin
        if (count_q != MinVal) count_d = count_q - One;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= Init;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_predictor_nbit.sv
// Direct-mapped table of n-bit saturating counters with registered lookup,
// resolve-driven training, mispredict pulse and saturating statistics.
module branch_predictor_nbit
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W  = DEF_IDX_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned STAT_W = DEF_STAT_W
) (
  input  logic              CLOCK,
  input  logic              INIT,
  input  logic              LOOKUP_EN,
  input  logic [IDX_W-1:0]  LOOKUP_ADDR,
  output logic              PREDICTION,
  output logic              PRED_VALID,
  input  logic              RESOLVE_EN,
  input  logic [IDX_W-1:0]  RESOLVE_ADDR,
  input  logic              OUTCOME,
  input  logic              PREDICTED,
  output logic              MISS,
  output logic [IDX_W-1:0]  ADDR_W,
  output logic [STAT_W-1:0] BRANCH_COUNT,
  output logic [STAT_W-1:0] MISS_COUNT
);

  localparam int unsigned Entries = 1 << IDX_W;
  localparam logic [STAT_W-1:0] StatOne = STAT_W'(1);
  localparam logic [STAT_W-1:0] StatMax = {STAT_W{1'b1}};

  logic [Entries-1:0][CNT_W-1:0] cnt_val;

  for (genvar i = 0; i < Entries; i++) begin : g_entry
    logic hit;
    assign hit = RESOLVE_EN && (RESOLVE_ADDR == IDX_W'(i));

    sat_counter #(
      .CNT_W    (CNT_W),
      .INIT_VAL (cnt_init(CNT_W))
    ) u_cnt (
      .clk   (CLOCK),
      .rst   (INIT),
      .en    (hit),
      .up    (OUTCOME),
      .count (cnt_val[i])
    );
  end

  logic              pred_q, pred_d;
  logic              valid_q;
  logic              miss_q, miss_d;
  logic [IDX_W-1:0]  addr_w_q, addr_w_d;
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Lookup reads the current (pre-update) counter, so a same-cycle resolve is not bypassed.
  always_comb begin
    pred_d       = pred_q;
    miss_d       = 1'b0;
    addr_w_d     = addr_w_q;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (LOOKUP_EN) pred_d = cnt_val[LOOKUP_ADDR][CNT_W-1];
    if (RESOLVE_EN) begin
      miss_d   = (OUTCOME != PREDICTED);
      addr_w_d = RESOLVE_ADDR;
      if (branch_cnt_q != StatMax) branch_cnt_d = branch_cnt_q + StatOne;
      if (miss_d && (miss_cnt_q != StatMax)) miss_cnt_d = miss_cnt_q + StatOne;
    end
  end

  always_ff @(posedge CLOCK or posedge INIT) begin
    if (INIT) begin
      pred_q       <= 1'b0;
      valid_q      <= 1'b0;
      miss_q       <= 1'b0;
      addr_w_q     <= '0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      pred_q       <= pred_d;
      valid_q      <= LOOKUP_EN;
      miss_q       <= miss_d;
      addr_w_q     <= addr_w_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign PREDICTION   = pred_q;
  assign PRED_VALID   = valid_q;
  assign MISS         = miss_q;
  assign ADDR_W       = addr_w_q;
  assign BRANCH_COUNT = branch_cnt_q;
  assign MISS_COUNT   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor_nbit.sv
// Directed bench: default predictor plus STAT_W=2 and CNT_W=1 variants on shared stimulus.
module tb_branch_predictor_nbit;

  logic       CLOCK = 1'b0;
  logic       INIT = 1'b0;
  logic       LOOKUP_EN = 1'b0;
  logic [2:0] LOOKUP_ADDR = '0;
  logic       RESOLVE_EN = 1'b0;
  logic [2:0] RESOLVE_ADDR = '0;
  logic       OUTCOME = 1'b0;
  logic       PREDICTED = 1'b0;

  logic        a_pred, a_valid, a_miss;
  logic [2:0]  a_addr_w;
  logic [15:0] a_bc, a_mc;
  logic        b_pred, b_valid, b_miss;
  logic [2:0]  b_addr_w;
  logic [1:0]  b_bc, b_mc;
  logic        c_pred, c_valid, c_miss;
  logic [2:0]  c_addr_w;
  logic [15:0] c_bc, c_mc;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK = ~CLOCK;

  branch_predictor_nbit u_dut_a (
    .CLOCK(CLOCK), .INIT(INIT), .LOOKUP_EN(LOOKUP_EN), .LOOKUP_ADDR(LOOKUP_ADDR),
    .PREDICTION(a_pred), .PRED_VALID(a_valid), .RESOLVE_EN(RESOLVE_EN),
    .RESOLVE_ADDR(RESOLVE_ADDR), .OUTCOME(OUTCOME), .PREDICTED(PREDICTED),
    .MISS(a_miss), .ADDR_W(a_addr_w), .BRANCH_COUNT(a_bc), .MISS_COUNT(a_mc)
  );

  branch_predictor_nbit #(.STAT_W(2)) u_dut_b (
    .CLOCK(CLOCK), .INIT(INIT), .LOOKUP_EN(LOOKUP_EN), .LOOKUP_ADDR(LOOKUP_ADDR),
    .PREDICTION(b_pred), .PRED_VALID(b_valid), .RESOLVE_EN(RESOLVE_EN),
    .RESOLVE_ADDR(RESOLVE_ADDR), .OUTCOME(OUTCOME), .PREDICTED(PREDICTED),
    .MISS(b_miss), .ADDR_W(b_addr_w), .BRANCH_COUNT(b_bc), .MISS_COUNT(b_mc)
  );

  branch_predictor_nbit #(.CNT_W(1)) u_dut_c (
    .CLOCK(CLOCK), .INIT(INIT), .LOOKUP_EN(LOOKUP_EN), .LOOKUP_ADDR(LOOKUP_ADDR),
    .PREDICTION(c_pred), .PRED_VALID(c_valid), .RESOLVE_EN(RESOLVE_EN),
    .RESOLVE_ADDR(RESOLVE_ADDR), .OUTCOME(OUTCOME), .PREDICTED(PREDICTED),
    .MISS(c_miss), .ADDR_W(c_addr_w), .BRANCH_COUNT(c_bc), .MISS_COUNT(c_mc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle();
    LOOKUP_EN  = 1'b0;
    RESOLVE_EN = 1'b0;
    OUTCOME    = 1'b0;
    PREDICTED  = 1'b0;
  endtask

  task automatic lookup(input logic [2:0] addr);
    LOOKUP_EN   = 1'b1;
    LOOKUP_ADDR = addr;
  endtask

  task automatic resolve(input logic [2:0] addr, input logic outcome, input logic predicted);
    RESOLVE_EN   = 1'b1;
    RESOLVE_ADDR = addr;
    OUTCOME      = outcome;
    PREDICTED    = predicted;
  endtask

  initial begin
    // Power-on reset
    #2 INIT = 1'b1;
    #1;
    check("rst_pred", 32'(a_pred), 0);
    check("rst_valid", 32'(a_valid), 0);
    check("rst_miss", 32'(a_miss), 0);
    check("rst_addr_w", 32'(a_addr_w), 0);
    check("rst_bc", 32'(a_bc), 0);
    check("rst_mc", 32'(a_mc), 0);
    tick();
    INIT = 1'b0;
    tick();

    // First lookup of addr 3: weak not-taken
    lookup(3'd3);
    tick();
    check("lk3_pred", 32'(a_pred), 0);
    check("lk3_valid", 32'(a_valid), 1);
    idle();
    tick();
    check("idle_valid", 32'(a_valid), 0);

    // Mispredicted taken resolve of addr 3: 01 -> 10
    resolve(3'd3, 1'b1, 1'b0);
    tick();
    check("res3_miss", 32'(a_miss), 1);
    check("res3_addr_w", 32'(a_addr_w), 3);
    check("res3_bc", 32'(a_bc), 1);
    check("res3_mc", 32'(a_mc), 1);
    idle();
    tick();
    check("miss_pulse_end", 32'(a_miss), 0);
    check("addr_w_hold", 32'(a_addr_w), 3);
    lookup(3'd3);
    tick();
    check("lk3_after_pred", 32'(a_pred), 1);
    idle();
    tick();
    check("pred_hold", 32'(a_pred), 1);
    check("pred_hold_valid", 32'(a_valid), 0);

    // Saturation on addr 2: 4 taken -> 11, one not-taken -> 10
    for (int i = 0; i < 4; i++) begin
      resolve(3'd2, 1'b1, 1'b1);
      tick();
    end
    resolve(3'd2, 1'b0, 1'b1);
    tick();
    check("sat_miss", 32'(a_miss), 1);
    check("sat_bc", 32'(a_bc), 6);
    check("sat_mc", 32'(a_mc), 2);
    idle();
    lookup(3'd2);
    tick();
    check("sat_lk2", 32'(a_pred), 1);
    idle();
    resolve(3'd2, 1'b0, 1'b0);
    tick();
    check("dec_no_miss", 32'(a_miss), 0);
    idle();
    lookup(3'd2);
    tick();
    check("dec_lk2", 32'(a_pred), 0);
    check("dec_bc", 32'(a_bc), 7);

    // Same-index lookup and resolve: no bypass
    idle();
    lookup(3'd5);
    resolve(3'd5, 1'b1, 1'b0);
    tick();
    check("same_pred", 32'(a_pred), 0);
    check("same_miss", 32'(a_miss), 1);
    idle();
    lookup(3'd5);
    tick();
    check("same_next_pred", 32'(a_pred), 1);
    check("same_mc", 32'(a_mc), 3);

    // Different indices in one cycle
    idle();
    lookup(3'd3);
    resolve(3'd6, 1'b0, 1'b0);
    tick();
    check("diff_pred", 32'(a_pred), 1);
    check("diff_addr_w", 32'(a_addr_w), 6);
    check("diff_bc", 32'(a_bc), 9);

    // Mid-cycle reset with a lookup and resolve in flight
    lookup(3'd4);
    resolve(3'd4, 1'b1, 1'b0);
    #2 INIT = 1'b1;
    #1;
    check("mid_rst_pred", 32'(a_pred), 0);
    check("mid_rst_valid", 32'(a_valid), 0);
    check("mid_rst_miss", 32'(a_miss), 0);
    check("mid_rst_bc", 32'(a_bc), 0);
    check("mid_rst_mc", 32'(a_mc), 0);
    check("mid_rst_addr_w", 32'(a_addr_w), 0);
    tick();
    check("held_rst_valid", 32'(a_valid), 0);
    check("held_rst_bc", 32'(a_bc), 0);
    idle();
    #2 INIT = 1'b0;
    tick();

    // Every entry weak not-taken: reads 0, one taken resolve flips it to 1
    for (int i = 0; i < 8; i++) begin
      idle();
      lookup(3'(i));
      tick();
      check($sformatf("init_lk%0d", i), 32'(a_pred), 0);
      check($sformatf("c_init_lk%0d", i), 32'(c_pred), 0);
      idle();
      resolve(3'(i), 1'b1, 1'b1);
      tick();
      idle();
      lookup(3'(i));
      tick();
      check($sformatf("weak_lk%0d", i), 32'(a_pred), 1);
      check($sformatf("c_weak_lk%0d", i), 32'(c_pred), 1);
    end
    check("post_loop_bc", 32'(a_bc), 8);
    check("post_loop_mc", 32'(a_mc), 0);
    check("b_bc_sat", 32'(b_bc), 3);

    // STAT_W=2: five mispredicts saturate MISS_COUNT at 3
    idle();
    for (int i = 0; i < 2; i++) begin
      resolve(3'd0, 1'b1, 1'b0);
      tick();
    end
    check("b_mc_2", 32'(b_mc), 2);
    for (int i = 0; i < 3; i++) begin
      resolve(3'd0, 1'b1, 1'b0);
      tick();
    end
    check("b_mc_sat", 32'(b_mc), 3);
    check("a_mc_5", 32'(a_mc), 5);
    check("a_bc_13", 32'(a_bc), 13);

    // CNT_W=1: last-outcome predictor
    idle();
    resolve(3'd7, 1'b1, 1'b1);
    tick();
    idle();
    lookup(3'd7);
    tick();
    check("c_taken_pred", 32'(c_pred), 1);
    idle();
    resolve(3'd7, 1'b0, 1'b1);
    tick();
    idle();
    lookup(3'd7);
    tick();
    check("c_nt_pred", 32'(c_pred), 0);
    check("a_nt_pred", 32'(a_pred), 1);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
